scan_chain_loader: RTL
======================

SCAN_CHAIN_LOADER -- requirements
Module: scan_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 20, total scan flops in the target chain (one 8-bit vertical plus one 12-bit horizontal connection block).
REQ-002 SHALL have parameter WORD_W, default 8, width of one bitstream word.
REQ-003 SHALL have port scan_clk, input, 1, sole clock, rising-edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse that begins a programming pass.
REQ-006 SHALL have port cfg_valid, input, 1, bitstream word valid.
REQ-007 SHALL have port cfg_data, input, WORD_W, bitstream word; LSB is shifted first.
REQ-008 SHALL have port cfg_ready, output, 1, word accepted when cfg_valid && cfg_ready at a rising edge.
REQ-009 SHALL have port scan_in, output, 1, serial data to the first chain flop.
REQ-010 SHALL have port scan_en, output, 1, chain shift enable.
REQ-011 SHALL have port scan_out, input, 1, serial data from the last chain flop.
REQ-012 SHALL have port busy, output, 1, high from the start edge until DONE.
REQ-013 SHALL have port done, output, 1, high in DONE until the next start.
REQ-014 SHALL have port error, output, 1, sticky readback mismatch flag.

Function
REQ-015 SHALL implement states IDLE, FETCH, SHIFT, VERIFY and DONE; VERIFY exists only under REQ-030.
REQ-016 SHALL leave IDLE or DONE for FETCH when start=1, clear the bit counter, and clear error; start in any other state SHALL be ignored.
REQ-017 SHALL assert cfg_ready only in FETCH; on a handshake it SHALL capture cfg_data and go to SHIFT on the next cycle.
REQ-018 SHALL register scan_in and scan_en, and in SHIFT SHALL drive scan_en=1 and scan_in equal to the current word bit, LSB first, for one cycle per bit.
REQ-019 SHALL count shifted bits as stream index k from 0 to CHAIN_LEN-1; after the final shift, stream bit k SHALL sit at chain position CHAIN_LEN-1-k, where position 0 is nearest scan_in.
REQ-020 SHALL return to FETCH after WORD_W bits unless k reached CHAIN_LEN-1; the number of words consumed SHALL equal ceil(CHAIN_LEN/WORD_W).
REQ-021 SHALL discard unused high bits of the last word without shifting them.
REQ-022 SHALL hold scan_en=0 in FETCH while cfg_valid=0 (stall), so the chain holds its value.
REQ-023 SHALL go to DONE (or to VERIFY under REQ-030) after shift CHAIN_LEN-1; in DONE it SHALL drive scan_en=0, busy=0 and done=1.
REQ-024 SHALL produce exactly CHAIN_LEN scan_en-high cycles per load pass, never more.

Reset
REQ-025 On rst=1 SHALL enter IDLE and set scan_en=0, scan_in=0, cfg_ready=0, busy=0, done=0 and error=0, with the counters zeroed at the next edge.
REQ-026 If reset is asserted mid-pass, the pass SHALL be abandoned and scan_en SHALL be 0 from the following cycle; chain contents are then partial and a new start is required.
REQ-027 SHALL give rst priority over start when both are high.

Configuration
REQ-028 Macro SCAN_READBACK_EN SHALL control readback.
REQ-029 Without SCAN_READBACK_EN, SHALL go directly from the last shift to DONE, with error tied to 0 and no shadow register.
REQ-030 With SCAN_READBACK_EN, SHALL keep a CHAIN_LEN-bit shadow copy of the shifted stream; after loading it SHALL enter VERIFY and re-shift the shadow for CHAIN_LEN cycles (re-shift bit j = shadow bit j), so the configuration is preserved.
REQ-031 In VERIFY, on each edge where registered scan_en=1, SHALL compare scan_out with shadow bit j; on any mismatch SHALL set error, which is held until the next start or rst.
REQ-032 Under SCAN_READBACK_EN, SHALL produce exactly 2*CHAIN_LEN scan_en-high cycles per pass.

Structure
REQ-033 The shared package SHALL hold the FSM state enum and the default CHAIN_LEN and WORD_W localparams.
REQ-034 SHALL use one sub-module, scan_bit_counter, holding the per-word bit index and the global index k with terminal-count flags.

Verification
REQ-035 Bench SHALL load CHAIN_LEN=20, WORD_W=8 with words 0xA5, 0x3C, 0x0F connected to a 20-flop model chain, expect 20 scan_en cycles and chain position 19-k equal to stream bit k, and expect 0x0F bits 4..7 never shifted.
REQ-036 Bench SHALL hold cfg_valid=0 for 5 cycles before the second word, expect scan_en=0 for those cycles and the same final chain image as REQ-035.
REQ-037 Bench SHALL pulse start in SHIFT and expect it ignored, with the bit count still 20 and done asserted once.
REQ-038 Bench SHALL assert rst at shift 9 and expect scan_en=0 and busy=0 on the next cycle, then a fresh start to load the full image correctly.
REQ-039 With SCAN_READBACK_EN and an intact chain, bench SHALL expect 40 shifts, error=0 and the chain image unchanged.
REQ-040 With SCAN_READBACK_EN and chain bit 7 forced stuck-at-0 with stream bit 12 = 1, bench SHALL expect error=1 in DONE, held until the next start.

Source files
------------

// File: rtl/scan_chain_loader_pkg.sv
// Shared types and defaults for the scan-chain loader: FSM state encoding, default chain/word sizes.
// Also holds a counter-width helper that stays legal for 1-entry ranges.
package scan_chain_loader_pkg;

  localparam int DEF_CHAIN_LEN = 20;
  localparam int DEF_WORD_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_VERIFY,
    ST_DONE
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_chain_loader_bit_counter.sv
// Bit-position tracker: per-word bit index and global stream index k, with terminal-count flags.
// Flags are combinational from the registers, so they describe the shift happening this cycle; inc advances, clr restarts.
module scan_bit_counter
  import scan_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int WORD_W    = DEF_WORD_W
) (
  input  logic scan_clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic bit_last,
  output logic k_last
);

  localparam int BW = cnt_w(WORD_W);
  localparam int KW = cnt_w(CHAIN_LEN);

  logic [BW-1:0] bit_idx;
  logic [KW-1:0] k;

  assign bit_last = (bit_idx == BW'(WORD_W - 1));
  assign k_last   = (k == KW'(CHAIN_LEN - 1));

  // k wraps to 0 after the last load shift so it can pace the readback pass too
  always_ff @(posedge scan_clk) begin
    if (rst || clr) begin
      bit_idx <= '0;
      k       <= '0;
    end else if (inc) begin
      bit_idx <= bit_last ? '0 : bit_idx + BW'(1);
      k       <= k_last ? '0 : k + KW'(1);
    end
  end

endmodule

// File: rtl/scan_chain_loader.sv
// Scan-chain programmer: WORD_W-bit words shifted LSB-first into a CHAIN_LEN chain, one bit per cycle after a 1-cycle capture.
// Stalls with scan_en=0 while cfg_valid is low in FETCH; SCAN_READBACK_EN adds a verifying re-shift with sticky error.
module scan_chain_loader
  import scan_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int WORD_W    = DEF_WORD_W
) (
  input  logic              scan_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_valid,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              scan_in,
  output logic              scan_en,
  input  logic              scan_out,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            state;
  logic [WORD_W-1:0] word;
  logic              bit_last;
  logic              k_last;
  logic              cnt_clr;
  logic              cnt_inc;

  assign cnt_clr = start && (state == ST_IDLE || state == ST_DONE);
  assign cnt_inc = (state == ST_SHIFT) || (state == ST_VERIFY);

  scan_bit_counter #(
    .CHAIN_LEN(CHAIN_LEN),
    .WORD_W   (WORD_W)
  ) u_cnt (
    .scan_clk(scan_clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .bit_last(bit_last),
    .k_last  (k_last)
  );

`ifdef SCAN_READBACK_EN
  logic [CHAIN_LEN-1:0] shadow;
  logic [CHAIN_LEN-1:0] shadow_nxt;
  logic                 error_q;

  // after the last load shift shadow[j] holds stream bit j
  assign shadow_nxt = {scan_in, shadow[CHAIN_LEN-1:1]};
  assign error      = error_q;
`else
  logic unused_scan_out;
  assign unused_scan_out = scan_out;
  assign error           = 1'b0;
`endif

  always_ff @(posedge scan_clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      scan_en   <= 1'b0;
      scan_in   <= 1'b0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      word      <= '0;
`ifdef SCAN_READBACK_EN
      shadow    <= '0;
      error_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_FETCH;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
`ifdef SCAN_READBACK_EN
            error_q   <= 1'b0;
`endif
          end
        end
        ST_FETCH: begin
          if (cfg_valid) begin
            word      <= cfg_data >> 1;
            scan_in   <= cfg_data[0];
            scan_en   <= 1'b1;
            cfg_ready <= 1'b0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
`ifdef SCAN_READBACK_EN
          shadow <= shadow_nxt;
`endif
          if (k_last) begin
`ifdef SCAN_READBACK_EN
            state   <= ST_VERIFY;
            scan_in <= shadow_nxt[0];
`else
            state   <= ST_DONE;
            scan_en <= 1'b0;
            scan_in <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
`endif
          end else if (bit_last) begin
            state     <= ST_FETCH;
            scan_en   <= 1'b0;
            scan_in   <= 1'b0;
            cfg_ready <= 1'b1;
          end else begin
            scan_in <= word[0];
            word    <= word >> 1;
          end
        end
`ifdef SCAN_READBACK_EN
        ST_VERIFY: begin
          // chain head presents stream bit j while shadow[0] holds it; rotation restores shadow
          if (scan_out != shadow[0]) error_q <= 1'b1;
          shadow  <= {shadow[0], shadow[CHAIN_LEN-1:1]};
          scan_in <= shadow[1];
          if (k_last) begin
            state   <= ST_DONE;
            scan_en <= 1'b0;
            scan_in <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
